// File: rtl/y86_wb_perf_monitor.sv
// y86_wb_perf_monitor: counts cycles/retires/stalls/bubbles from the W stage and freezes on halt, fault or watchdog
module y86_wb_perf_monitor #(
  parameter int CNT_W = 32,
  parameter int WDOG_LIMIT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [3:0]       W_icode,
  input  logic [1:0]       W_stat,
  input  logic             W_stall,
  input  logic             F_stall,
  input  logic             D_bubble,
  input  logic             E_bubble,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] retired_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [1:0]       state,
  output logic [1:0]       fault_stat,
  output logic             wdog_trip,
  output logic             done
);
  typedef enum logic [1:0] {RUN = 2'd0, HALTED = 2'd1, FAULT = 2'd2} st_t;
  st_t st, st_nx;
  logic [15:0] idle;
  logic run, live, retire, hlt, flt, trip;
  assign run = st == RUN;
  assign live = run && !W_stall;
  assign retire = live && W_icode != 4'd1 && !W_stat[1];
  assign hlt = live && W_stat == 2'd1;
  assign flt = live && W_stat[1];
  // real status events outrank the watchdog
  assign trip = run && !retire && !hlt && !flt && ({1'b0, idle} + 17'd1 == 17'(WDOG_LIMIT));
  assign state = st;
  function automatic logic [CNT_W-1:0] inc(input logic [CNT_W-1:0] c, input logic en);
    return (en && c != '1) ? c + CNT_W'(1) : c;
  endfunction
  always_comb begin
    st_nx = st;
    if (run) st_nx = hlt ? HALTED : (flt || trip) ? FAULT : RUN;
  end
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      st <= RUN;
      idle <= '0;
      cycle_cnt <= '0;
      retired_cnt <= '0;
      stall_cnt <= '0;
      bubble_cnt <= '0;
      fault_stat <= '0;
      wdog_trip <= 1'b0;
      done <= 1'b0;
    end else begin
      st <= st_nx;
      done <= run && st_nx != RUN;
      if (run) begin
        cycle_cnt <= inc(cycle_cnt, 1'b1);
        retired_cnt <= inc(retired_cnt, retire);
        stall_cnt <= inc(stall_cnt, F_stall);
        bubble_cnt <= inc(bubble_cnt, D_bubble || E_bubble);
        idle <= retire ? '0 : idle + 16'd1;
        fault_stat <= flt ? W_stat : fault_stat;
        wdog_trip <= trip;
      end
    end
  end
endmodule
